shift_req_fifo: RTL

Request-buffering front end for the 8-bit logical right barrel shifter. It accepts `{data, shift magnitude}` requests over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head entry combinationally to the shifter's `in`/`shmag` inputs, then captures the shifter's `out` into a registered, back-pressurable output stage. It lets the purely combinational shifter run in a streaming datapath at one result per cycle.

---
 rtl/shift_req_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/shift_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : shift_req_fifo
// Purpose  : Request FIFO and registered output stage wrapped around an
//            external combinational 8-bit logical right barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_req_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_shmag,
  output logic [7:0]    sh_in,
  output logic [2:0]    sh_shmag,
  input  logic [7:0]    sh_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [2:0]    out_shmag,
  output logic [CW-1:0] count
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [7:0]    r_mem_data  [DEPTH];
  logic [2:0]    r_mem_shmag [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic [2:0]    r_out_shmag;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Acceptance depends only on registered occupancy, never on a same-cycle pop.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != C_DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && (!r_out_valid || out_ready);

  assign sh_in    = w_empty ? 8'd0 : r_mem_data[r_rptr];
  assign sh_shmag = w_empty ? 3'd0 : r_mem_shmag[r_rptr];

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_shmag = r_out_shmag;
  assign count     = r_count;

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr]  <= in_data;
      r_mem_shmag[r_wptr] <= in_shmag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_shmag <= 3'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + AW'(1);
        r_out_data  <= sh_out;
        r_out_shmag <= sh_shmag;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
